alu_result_skid: RTL and testbench

2-entry registered skid buffer directly downstream of the ALU. It captures each ALU result word together with its flags (carryout, zero, overflow) and the 3-bit command that produced it, and hands them to the next stage over a valid/ready handshake. It also keeps a saturating count of accepted results that signalled overflow. Its purpose is to break the combinational path from ALU outputs into the consumer and to absorb one cycle of downstream stall without losing data.

---
 rtl/alu_result_skid.sv | 110 +++++++++++
 tb/tb_alu_result_skid.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_skid.sv
// Two-entry registered skid buffer between the ALU and its consumer.
// Carries result, flags and command tag; counts accepted overflow results.
module alu_result_skid #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_result,
    input  logic                 in_carryout,
    input  logic                 in_zero,
    input  logic                 in_overflow,
    input  logic [2:0]           in_command,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_carryout,
    output logic                 out_zero,
    output logic                 out_overflow,
    output logic [2:0]           out_command,
    output logic [CNT_WIDTH-1:0] ovf_count,
    input  logic                 clear_count
);

    localparam int EW = WIDTH + 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [EW-1:0]        head_q, head_d;
    logic [EW-1:0]        skid_q, skid_d;
    logic [EW-1:0]        in_word;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 accept, pop;
    logic                 load_head_in, load_head_skid, load_skid;

    assign in_word = {in_result, in_carryout, in_zero, in_overflow, in_command};
    assign accept  = in_valid & in_ready;
    assign pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !pop)      state_d = FULL;
                else if (pop && !accept) state_d = EMPTY;
            end
            FULL:  if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs come from the state register only.
    always_comb begin
        in_ready       = (state_q != FULL);
        out_valid      = (state_q == ONE) || (state_q == FULL);
        load_head_in   = ((state_q == EMPTY) && accept)
                       || ((state_q == ONE) && accept && pop);
        load_skid      = (state_q == ONE) && accept && !pop;
        load_head_skid = (state_q == FULL) && pop;
    end

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        if (load_head_skid)    head_d = skid_q;
        else if (load_head_in) head_d = in_word;
        if (load_skid)         skid_d = in_word;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (accept && in_overflow && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign {out_result, out_carryout, out_zero, out_overflow, out_command} = head_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_alu_result_skid.sv
// Directed bench for alu_result_skid with a FIFO scoreboard on the output.
// Runs with CNT_WIDTH=2 so counter saturation is reachable.
module tb_alu_result_skid;

    localparam int WIDTH = 32;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carryout, in_zero, in_overflow;
    logic [2:0]       in_command;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carryout, out_zero, out_overflow;
    logic [2:0]       out_command;
    logic [CW-1:0]    ovf_count;
    logic             clear_count;

    int ncmp = 0;
    int nerr = 0;
    int pops = 0;
    int pops_mark;
    logic [WIDTH+5:0] sb[$];

    alu_result_skid #(.WIDTH(WIDTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carryout(in_carryout),
        .in_zero(in_zero), .in_overflow(in_overflow),
        .in_command(in_command),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carryout(out_carryout),
        .out_zero(out_zero), .out_overflow(out_overflow),
        .out_command(out_command),
        .ovf_count(ovf_count), .clear_count(clear_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic c,
                         input logic z, input logic o, input logic [2:0] cmd);
        in_valid    = v;
        in_result   = r;
        in_carryout = c;
        in_zero     = z;
        in_overflow = o;
        in_command  = cmd;
    endtask

    // Pop before push: the head seen here was accepted on an earlier edge.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    chk("sb_word",
                        64'({out_result, out_carryout, out_zero,
                             out_overflow, out_command}),
                        64'(sb.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({in_result, in_carryout, in_zero,
                              in_overflow, in_command});
            end
        end
    end

    initial begin
        reset       = 1'b1;
        out_ready   = 1'b0;
        clear_count = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 3'b111);
        step();
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_word",
            64'({out_result, out_carryout, out_zero, out_overflow, out_command}),
            64'd0);
        chk("rst_ovf", 64'(ovf_count), 64'd0);

        // Pass-through
        out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("pt_valid", 64'(out_valid), 64'd1);
        chk("pt_result", 64'(out_result), 64'hFFFF_FFFE);
        chk("pt_flags", 64'({out_carryout, out_zero, out_overflow}), 64'b100);
        chk("pt_cmd", 64'(out_command), 64'd0);
        step();
        chk("pt_drain", 64'(out_valid), 64'd0);

        // Back-to-back stream: accept+pop in ONE every cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000_0000 + 32'(i), i[0], i[1], 1'b0, i[2:0]);
            step();
            chk("st_valid", 64'(out_valid), 64'd1);
            chk("st_ready", 64'(in_ready), 64'd1);
            chk("st_result", 64'(out_result), 64'h1000_0000 + 64'(i));
            chk("st_cmd", 64'(out_command), 64'(i[2:0]));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("st_drain", 64'(out_valid), 64'd0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 3'b001);
        step();
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        chk("bp_a_head", 64'(out_result), 64'h1);
        drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 3'b010);
        step();
        chk("bp_b_ready", 64'(in_ready), 64'd0);
        chk("bp_b_head", 64'(out_result), 64'h1);
        drive(1'b1, 32'h3, 1'b0, 1'b1, 1'b0, 3'b011);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_head",
                64'({out_result, out_command}), 64'({32'h1, 3'b001}));
        end
        out_ready = 1'b1;
        step();
        chk("bp_pop1_head", 64'(out_result), 64'h2);
        chk("bp_recover", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("bp_pop2_head", 64'(out_result), 64'h3);
        step();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Saturating overflow counter
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b1, 3'b101);
            step();
            chk("ovf_sat", 64'(ovf_count), (i < 3) ? 64'(i + 1) : 64'd3);
        end
        drive(1'b0, 32'h200, 1'b0, 1'b0, 1'b1, 3'b101);
        step();
        chk("ovf_noacc", 64'(ovf_count), 64'd3);
        clear_count = 1'b1;
        drive(1'b1, 32'h201, 1'b0, 1'b0, 1'b1, 3'b101);
        step();
        clear_count = 1'b0;
        chk("ovf_clr_wins", 64'(ovf_count), 64'd0);
        step();
        chk("ovf_after_clr", 64'(ovf_count), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();

        // Reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1, 3'b110);
        step();
        drive(1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 1'b1, 3'b110);
        step();
        chk("rf_full", 64'(in_ready), 64'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        chk("rf_valid", 64'(out_valid), 64'd0);
        chk("rf_ready", 64'(in_ready), 64'd1);
        chk("rf_ovf", 64'(ovf_count), 64'd0);
        pops_mark = pops;
        drive(1'b1, 32'h5555_0D0D, 1'b1, 1'b1, 1'b0, 3'b100);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("rf_first", 64'(out_result), 64'h5555_0D0D);
        step();
        step();
        chk("rf_only_one", 64'(pops - pops_mark), 64'd1);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
